apb_slave_mem: RTL and testbench

- APB responder that terminates the APB side of the AHB-to-APB bridge. It acts as the peripheral behind one bridge Pselx line.
- Implements a word-addressed register memory with programmable wait states (Pready) and error responses (Pslverr) for illegal addresses.
- Includes a sticky protocol checker that flags bridge-side APB sequencing violations.
- Shares the bridge clock and reset. Used as the DUT's APB load in the bridge environment and as standalone RTL.

---
 rtl/apb_slave_mem.sv | 134 +++++++++++++
 tb/tb_apb_slave_mem.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// APB responder backed by a word-addressed register memory, with programmable
// wait states, error responses for illegal addresses and a sticky protocol checker.
module apb_slave_mem #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                    SEL_IDX     = 0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic [2:0]            Pselx,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [ADDR_WIDTH-1:0] Paddr,
  input  logic [DATA_WIDTH-1:0] Pwdata,
  output logic [DATA_WIDTH-1:0] Prdata,
  output logic                  Pready,
  output logic                  Pslverr,
  output logic                  proto_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so BASE_ADDR + 4*DEPTH cannot wrap at the top of the address map.
  localparam logic [ADDR_WIDTH:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] END_EXT   = BASE_EXT + (ADDR_WIDTH+1)'(4 * DEPTH);
  localparam logic [3:0]          WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  function automatic logic addr_legal(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= BASE_EXT) && ({1'b0, a} < END_EXT) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return off[IDX_W+1:2];
  endfunction

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [DATA_WIDTH-1:0]  rd_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   write_q;
  logic                   legal_q;
  logic                   proto_q;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic                   sel;
  logic                   legal_in;
  logic [IDX_W-1:0]       idx_in;
  logic                   ready_c;
  logic                   viol;
  logic                   commit;

  assign sel      = Pselx[SEL_IDX];
  assign legal_in = addr_legal(Paddr);
  assign idx_in   = addr_idx(Paddr);
  assign ready_c  = (state_q == ACCESS) && (cnt_q == 4'd0);

  assign Pready    = ready_c;
  assign Pslverr   = ready_c && !legal_q;
  assign Prdata    = (ready_c && !write_q && legal_q) ? rd_q : '0;
  assign proto_err = proto_q;

  always_comb begin
    state_d = state_q;
    viol    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel && Penable) viol = 1'b1;
        else if (sel)       state_d = SETUP;
      end
      SETUP: begin
        viol    = Penable;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          commit  = write_q && legal_q;
          state_d = (sel && !Penable) ? SETUP : IDLE;
        end else begin
          // While stalled the bridge must hold the whole request steady.
          viol = !sel || (Paddr != addr_q) || (Pwrite != write_q) || (Pwdata != wdata_q);
          if (!sel) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      legal_q <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (viol) proto_q <= 1'b1;
      if (state_q == SETUP) begin
        cnt_q   <= WAIT_INIT;
        addr_q  <= Paddr;
        wdata_q <= Pwdata;
        write_q <= Pwrite;
        legal_q <= legal_in;
        idx_q   <= idx_in;
        rd_q    <= legal_in ? mem[idx_in] : '0;
      end else if ((state_q == ACCESS) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // A read's SETUP edge follows any preceding write's commit edge, so it sees new data.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench: three responders on one APB bus (selects 0/1/2 with 0/3/2 wait states).
module tb_apb_slave_mem;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] prdata [3];
  logic        pready [3];
  logic        pslverr [3];
  logic        proto_err [3];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_cnt  = 0;

  always #5 Hclk = ~Hclk;
  always @(posedge Hclk) cyc_cnt <= cyc_cnt + 1;

  apb_slave_mem #(.SEL_IDX(0), .WAIT_STATES(0)) u0 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata[0]), .Pready(pready[0]),
    .Pslverr(pslverr[0]), .proto_err(proto_err[0]));

  apb_slave_mem #(.SEL_IDX(1), .WAIT_STATES(3)) u1 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata[1]), .Pready(pready[1]),
    .Pslverr(pslverr[1]), .proto_err(proto_err[1]));

  apb_slave_mem #(.SEL_IDX(2), .WAIT_STATES(2)) u2 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata[2]), .Pready(pready[2]),
    .Pslverr(pslverr[2]), .proto_err(proto_err[2]));

  // Drives one transfer to slave s; starts in an IDLE or completing-ACCESS cycle and
  // returns at the falling edge of the completing ACCESS cycle.
  task automatic xfer(input int s, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic err,
                      output int waits, output int setup_c, output int done_c);
    int guard;
    Pselx = 3'b000; Pselx[s] = 1'b1;
    Penable = 1'b0; Pwrite = wr; Paddr = addr; Pwdata = wd;
    @(posedge Hclk); #1;
    setup_c = cyc_cnt;
    @(posedge Hclk); #1;
    Penable = 1'b1;
    waits = 0; guard = 0;
    forever begin
      @(negedge Hclk);
      if (pready[s] === 1'b1) break;
      waits++; guard++;
      if (guard > 20) break;
      @(posedge Hclk); #1;
    end
    done_c = cyc_cnt;
    if (guard > 20) begin
      rd = 'x; err = 1'bx; waits = -1;
    end else begin
      rd = prdata[s]; err = pslverr[s];
    end
  endtask

  task automatic idle();
    Pselx = 3'b000; Penable = 1'b0;
    @(posedge Hclk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err; int w, sc, dc;
    Hresetn = 1'b0; Pselx = 3'b001; Penable = 1'b1; Pwrite = 1'b1;
    Paddr = 32'h8000_0000; Pwdata = 32'h5555_5555;
    repeat (2) @(posedge Hclk);
    @(negedge Hclk);
    n_checks++; if (prdata[0] !== 32'h0) $display("FAIL rst_prdata: got %h want 0", prdata[0]); else n_pass++;
    n_checks++; if (pready[0] !== 1'b0) $display("FAIL rst_pready: got %b want 0", pready[0]); else n_pass++;
    n_checks++; if (pslverr[0] !== 1'b0) $display("FAIL rst_pslverr: got %b want 0", pslverr[0]); else n_pass++;
    n_checks++; if (proto_err[0] !== 1'b0) $display("FAIL rst_proto_err: got %b want 0", proto_err[0]); else n_pass++;
    Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0;
    Hresetn = 1'b1;
    @(posedge Hclk); #1;
    xfer(0, 1'b0, 32'h8000_0000, 32'h0, rd, err, w, sc, dc);
    n_checks++; if (rd !== 32'h0) $display("FAIL rst_read_data: got %h want 0", rd); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL rst_read_err: got %b want 0", err); else n_pass++;
    idle();
    // Abort a write on slave 1 in its completing cycle.
    Pselx = 3'b010; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h8000_0020; Pwdata = 32'hCAFE_F00D;
    @(posedge Hclk); #1;
    @(posedge Hclk); #1;
    Penable = 1'b1;
    repeat (3) begin @(posedge Hclk); #1; end
    n_checks++; if (pready[1] !== 1'b1) $display("FAIL abort_pre_ready: got %b want 1", pready[1]); else n_pass++;
    Hresetn = 1'b0;
    #1;
    n_checks++; if (pready[1] !== 1'b0) $display("FAIL abort_async_ready: got %b want 0", pready[1]); else n_pass++;
    Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0;
    @(negedge Hclk);
    Hresetn = 1'b1;
    @(posedge Hclk); #1;
    xfer(1, 1'b0, 32'h8000_0020, 32'h0, rd, err, w, sc, dc);
    n_checks++; if (rd !== 32'h0) $display("FAIL abort_no_write: got %h want 0", rd); else n_pass++;
    idle();
  endtask

  task automatic test_ws0();
    logic [31:0] rd; logic err; int w, sc, dc;
    xfer(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, rd, err, w, sc, dc);
    n_checks++; if (err !== 1'b0) $display("FAIL ws0_wr_err: got %b want 0", err); else n_pass++;
    n_checks++; if (rd !== 32'h0) $display("FAIL ws0_wr_prdata: got %h want 0", rd); else n_pass++;
    n_checks++; if (dc - sc + 1 != 2) $display("FAIL ws0_wr_cycles: got %0d want 2", dc - sc + 1); else n_pass++;
    idle();
    xfer(0, 1'b0, 32'h8000_0010, 32'h0, rd, err, w, sc, dc);
    n_checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL ws0_rd_data: got %h want deadbeef", rd); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL ws0_rd_err: got %b want 0", err); else n_pass++;
    n_checks++; if (w != 0) $display("FAIL ws0_rd_waits: got %0d want 0", w); else n_pass++;
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int w, sc0, sc, dc;
    xfer(0, 1'b1, 32'h8000_0000, 32'h1111_1111, rd, err, w, sc0, dc);
    xfer(0, 1'b1, 32'h8000_0004, 32'h2222_2222, rd, err, w, sc, dc);
    xfer(0, 1'b1, 32'h8000_0008, 32'h3333_3333, rd, err, w, sc, dc);
    n_checks++; if (dc - sc0 + 1 != 6) $display("FAIL b2b_cycles: got %0d want 6", dc - sc0 + 1); else n_pass++;
    xfer(0, 1'b0, 32'h8000_0008, 32'h0, rd, err, w, sc, dc);
    n_checks++; if (rd !== 32'h3333_3333) $display("FAIL b2b_wr_then_rd: got %h want 33333333", rd); else n_pass++;
    idle();
    xfer(0, 1'b0, 32'h8000_0000, 32'h0, rd, err, w, sc, dc);
    n_checks++; if (rd !== 32'h1111_1111) $display("FAIL b2b_rd0: got %h want 11111111", rd); else n_pass++;
    xfer(0, 1'b0, 32'h8000_0004, 32'h0, rd, err, w, sc, dc);
    n_checks++; if (rd !== 32'h2222_2222) $display("FAIL b2b_rd1: got %h want 22222222", rd); else n_pass++;
    idle();
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic err; int w, sc, dc;
    xfer(0, 1'b1, 32'h8000_0400, 32'hFFFF_FFFF, rd, err, w, sc, dc);
    n_checks++; if (err !== 1'b1) $display("FAIL ill_wr_oob_err: got %b want 1", err); else n_pass++;
    idle();
    @(negedge Hclk);
    n_checks++; if (pslverr[0] !== 1'b0) $display("FAIL ill_err_one_cycle: got %b want 0", pslverr[0]); else n_pass++;
    xfer(0, 1'b0, 32'h8000_0000, 32'h0, rd, err, w, sc, dc);
    n_checks++; if (rd !== 32'h1111_1111) $display("FAIL ill_mem_unchanged: got %h want 11111111", rd); else n_pass++;
    idle();
    xfer(0, 1'b0, 32'h8000_0002, 32'h0, rd, err, w, sc, dc);
    n_checks++; if (err !== 1'b1) $display("FAIL ill_rd_unaligned_err: got %b want 1", err); else n_pass++;
    n_checks++; if (rd !== 32'h0) $display("FAIL ill_rd_unaligned_data: got %h want 0", rd); else n_pass++;
    idle();
    xfer(0, 1'b0, 32'h7FFF_FFFC, 32'h0, rd, err, w, sc, dc);
    n_checks++; if (err !== 1'b1) $display("FAIL ill_rd_below_base: got %b want 1", err); else n_pass++;
    idle();
    xfer(0, 1'b1, 32'h8000_03FC, 32'h0BAD_CAFE, rd, err, w, sc, dc);
    n_checks++; if (err !== 1'b0) $display("FAIL ill_last_word_err: got %b want 0", err); else n_pass++;
    idle();
    xfer(0, 1'b0, 32'h8000_03FC, 32'h0, rd, err, w, sc, dc);
    n_checks++; if (rd !== 32'h0BAD_CAFE) $display("FAIL ill_last_word_data: got %h want 0badcafe", rd); else n_pass++;
    idle();
  endtask

  task automatic test_ws3();
    logic [31:0] rd; logic err; int w, sc, dc;
    xfer(1, 1'b1, 32'h8000_0040, 32'hA5A5_0F0F, rd, err, w, sc, dc);
    n_checks++; if (w != 3) $display("FAIL ws3_wr_waits: got %0d want 3", w); else n_pass++;
    idle();
    xfer(1, 1'b0, 32'h8000_0040, 32'h0, rd, err, w, sc, dc);
    n_checks++; if (w != 3) $display("FAIL ws3_rd_waits: got %0d want 3", w); else n_pass++;
    n_checks++; if (dc - sc != 4) $display("FAIL ws3_rd_latency: got %0d want 4", dc - sc); else n_pass++;
    n_checks++; if (rd !== 32'hA5A5_0F0F) $display("FAIL ws3_rd_data: got %h want a5a50f0f", rd); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL ws3_rd_err: got %b want 0", err); else n_pass++;
    n_checks++; if (proto_err[1] !== 1'b0) $display("FAIL ws3_proto_err: got %b want 0", proto_err[1]); else n_pass++;
    idle();
  endtask

  task automatic test_proto();
    n_checks++; if (proto_err[0] !== 1'b0) $display("FAIL pa_before: got %b want 0", proto_err[0]); else n_pass++;
    Pselx = 3'b001; Penable = 1'b1;
    @(posedge Hclk); #1;
    Pselx = 3'b000; Penable = 1'b0;
    @(negedge Hclk);
    n_checks++; if (proto_err[0] !== 1'b1) $display("FAIL pa_set: got %b want 1", proto_err[0]); else n_pass++;
    repeat (3) begin @(posedge Hclk); #1; end
    n_checks++; if (proto_err[0] !== 1'b1) $display("FAIL pa_sticky: got %b want 1", proto_err[0]); else n_pass++;
    n_checks++; if (proto_err[1] !== 1'b0) $display("FAIL pa_other_slave: got %b want 0", proto_err[1]); else n_pass++;
    // Address changes during the first wait cycle of slave 2.
    Pselx = 3'b100; Penable = 1'b0; Pwrite = 1'b0; Paddr = 32'h8000_0050; Pwdata = 32'h0;
    @(posedge Hclk); #1;
    @(posedge Hclk); #1;
    Penable = 1'b1; Paddr = 32'h8000_0054;
    @(negedge Hclk);
    n_checks++; if (proto_err[2] !== 1'b0) $display("FAIL pb_before_edge: got %b want 0", proto_err[2]); else n_pass++;
    @(posedge Hclk); #1;
    Paddr = 32'h8000_0050;
    @(negedge Hclk);
    n_checks++; if (proto_err[2] !== 1'b1) $display("FAIL pb_set: got %b want 1", proto_err[2]); else n_pass++;
    @(posedge Hclk); #1;
    @(negedge Hclk);
    n_checks++; if (pready[2] !== 1'b1) $display("FAIL pb_completes: got %b want 1", pready[2]); else n_pass++;
    idle();
    Hresetn = 1'b0;
    #2;
    Hresetn = 1'b1;
    @(negedge Hclk);
    n_checks++; if (proto_err[0] !== 1'b0) $display("FAIL prst_clear0: got %b want 0", proto_err[0]); else n_pass++;
    n_checks++; if (proto_err[2] !== 1'b0) $display("FAIL prst_clear2: got %b want 0", proto_err[2]); else n_pass++;
  endtask

  initial begin
    Hresetn = 1'b1; Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0;
    Paddr = 32'h0; Pwdata = 32'h0;
    #2;
    test_reset();
    test_ws0();
    test_back_to_back();
    test_illegal();
    test_ws3();
    test_proto();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
